// File: rtl/program_loader.sv
// Boot/restart sequencer: holds the core in reset, streams an image into program
// memory, waits a settle interval, then releases the core.
module program_loader #(
    parameter int ADDR_W        = 10,
    parameter int INSTR_W       = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               pm_write,
    output logic [ADDR_W-1:0]  pm_address,
    output logic [INSTR_W-1:0] pm_data,
    output logic               core_reset,
    output logic               busy,
    output logic               error,
    output logic [ADDR_W:0]    loaded_words
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] ERROR  = 3'd4;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]   SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W:0] FULL        = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]      state;
    logic [ADDR_W:0] count;
    logic [SW-1:0]   settle_cnt;
    logic            transfer;

    assign in_ready   = (state == LOAD);
    assign busy       = (state == LOAD) || (state == SETTLE);
    assign core_reset = (state == RUN);
    assign error      = (state == ERROR);
    assign transfer   = in_valid & in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            settle_cnt   <= '0;
            pm_write     <= 1'b0;
            pm_address   <= '0;
            pm_data      <= '0;
            loaded_words <= '0;
        end else begin
            pm_write <= 1'b0;
            // start overrides everything, including a same-cycle transfer
            if (start) begin
                state <= LOAD;
                count <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        if (transfer) begin
                            // count can reach 2^ADDR_W; one more word is an overflow
                            if (count == FULL) begin
                                state <= ERROR;
                            end else begin
                                pm_write   <= 1'b1;
                                pm_address <= count[ADDR_W-1:0];
                                pm_data    <= in_data;
                                count      <= count + 1'b1;
                                if (in_last) begin
                                    state        <= SETTLE;
                                    loaded_words <= count + 1'b1;
                                    settle_cnt   <= SETTLE_INIT;
                                end
                            end
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt == '0) begin
                            state <= RUN;
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end
                    IDLE, RUN, ERROR: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed checks of program_loader: a 10-bit-address instance driven from a vector
// table, and a 2-bit-address instance for overflow / full-memory corner cases.
module tb_program_loader;

    logic clock;
    logic reset;

    logic        a_start, a_valid, a_last;
    logic [15:0] a_data;
    logic        a_ready, a_pw, a_cr, a_busy, a_err;
    logic [9:0]  a_pa;
    logic [15:0] a_pd;
    logic [10:0] a_lw;

    logic        b_start, b_valid, b_last;
    logic [15:0] b_data;
    logic        b_ready, b_pw, b_cr, b_busy, b_err;
    logic [1:0]  b_pa;
    logic [15:0] b_pd;
    logic [2:0]  b_lw;

    int n_vec;
    int n_bad;

    program_loader #(.ADDR_W(10), .INSTR_W(16), .SETTLE_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .in_valid(a_valid),
        .in_data(a_data), .in_last(a_last), .in_ready(a_ready), .pm_write(a_pw),
        .pm_address(a_pa), .pm_data(a_pd), .core_reset(a_cr), .busy(a_busy),
        .error(a_err), .loaded_words(a_lw)
    );

    program_loader #(.ADDR_W(2), .INSTR_W(16), .SETTLE_CYCLES(4)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .in_valid(b_valid),
        .in_data(b_data), .in_last(b_last), .in_ready(b_ready), .pm_write(b_pw),
        .pm_address(b_pa), .pm_data(b_pd), .core_reset(b_cr), .busy(b_busy),
        .error(b_err), .loaded_words(b_lw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        st;
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        rdy;
        logic        pw;
        logic [9:0]  pa;
        logic [15:0] pd;
        logic        cr;
        logic        bsy;
        logic        err;
        logic [10:0] lw;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic st, input logic v, input logic [15:0] d, input logic l);
        a_start = st; a_valid = v; a_data = d; a_last = l;
    endtask

    task automatic drive_b(input logic st, input logic v, input logic [15:0] d, input logic l);
        b_start = st; b_valid = v; b_data = d; b_last = l;
    endtask

    task automatic check_a(input int i, input vec_t x);
        chk("a_in_ready", i, 32'(a_ready), 32'(x.rdy));
        chk("a_pm_write", i, 32'(a_pw), 32'(x.pw));
        chk("a_pm_address", i, 32'(a_pa), 32'(x.pa));
        chk("a_pm_data", i, 32'(a_pd), 32'(x.pd));
        chk("a_core_reset", i, 32'(a_cr), 32'(x.cr));
        chk("a_busy", i, 32'(a_busy), 32'(x.bsy));
        chk("a_error", i, 32'(a_err), 32'(x.err));
        chk("a_loaded_words", i, 32'(a_lw), 32'(x.lw));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        drive_a(0, 0, 16'h0, 0);
        drive_b(0, 0, 16'h0, 0);

        //           st v  d        l  rdy pw pa  pd       cr bsy err lw
        tab.push_back('{1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 0});
        tab.push_back('{0, 1, 16'h1111, 0, 1, 1, 0, 16'h1111, 0, 1, 0, 0});
        tab.push_back('{0, 1, 16'h2222, 0, 1, 1, 1, 16'h2222, 0, 1, 0, 0});
        tab.push_back('{0, 1, 16'h3333, 1, 0, 1, 2, 16'h3333, 0, 1, 0, 3});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 2, 16'h3333, 0, 1, 0, 3});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 2, 16'h3333, 0, 1, 0, 3});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 2, 16'h3333, 0, 1, 0, 3});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 2, 16'h3333, 1, 0, 0, 3});
        tab.push_back('{0, 1, 16'hDEAD, 0, 0, 0, 2, 16'h3333, 1, 0, 0, 3});
        // restart from RUN, then valid toggling 1,0,1,0,1
        tab.push_back('{1, 0, 16'h0000, 0, 1, 0, 2, 16'h3333, 0, 1, 0, 3});
        tab.push_back('{0, 1, 16'hA001, 0, 1, 1, 0, 16'hA001, 0, 1, 0, 3});
        tab.push_back('{0, 0, 16'hA0FF, 0, 1, 0, 0, 16'hA001, 0, 1, 0, 3});
        tab.push_back('{0, 1, 16'hA002, 0, 1, 1, 1, 16'hA002, 0, 1, 0, 3});
        tab.push_back('{0, 0, 16'hA0FF, 0, 1, 0, 1, 16'hA002, 0, 1, 0, 3});
        tab.push_back('{0, 1, 16'hA003, 1, 0, 1, 2, 16'hA003, 0, 1, 0, 3});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 2, 16'hA003, 0, 1, 0, 3});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 2, 16'hA003, 0, 1, 0, 3});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 2, 16'hA003, 0, 1, 0, 3});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 2, 16'hA003, 1, 0, 0, 3});
        // single-word reload from RUN
        tab.push_back('{1, 0, 16'h0000, 0, 1, 0, 2, 16'hA003, 0, 1, 0, 3});
        tab.push_back('{0, 1, 16'h0042, 1, 0, 1, 0, 16'h0042, 0, 1, 0, 1});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0042, 0, 1, 0, 1});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0042, 0, 1, 0, 1});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0042, 0, 1, 0, 1});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0042, 1, 0, 0, 1});
        // start beats a same-cycle last transfer; start during SETTLE restarts
        tab.push_back('{1, 0, 16'h0000, 0, 1, 0, 0, 16'h0042, 0, 1, 0, 1});
        tab.push_back('{0, 1, 16'h5555, 0, 1, 1, 0, 16'h5555, 0, 1, 0, 1});
        tab.push_back('{0, 1, 16'h5656, 0, 1, 1, 1, 16'h5656, 0, 1, 0, 1});
        tab.push_back('{1, 1, 16'h6666, 1, 1, 0, 1, 16'h5656, 0, 1, 0, 1});
        tab.push_back('{0, 1, 16'h7777, 1, 0, 1, 0, 16'h7777, 0, 1, 0, 1});
        tab.push_back('{1, 0, 16'h0000, 0, 1, 0, 0, 16'h7777, 0, 1, 0, 1});
        tab.push_back('{0, 1, 16'h8888, 0, 1, 1, 0, 16'h8888, 0, 1, 0, 1});
        tab.push_back('{0, 1, 16'h9999, 1, 0, 1, 1, 16'h9999, 0, 1, 0, 2});
        tab.push_back('{0, 1, 16'hBEEF, 0, 0, 0, 1, 16'h9999, 0, 1, 0, 2});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 1, 16'h9999, 0, 1, 0, 2});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 1, 16'h9999, 0, 1, 0, 2});
        tab.push_back('{0, 0, 16'h0000, 0, 0, 0, 1, 16'h9999, 1, 0, 0, 2});

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_a(-1, '{0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0});
        chk("b_reset_core", -1, 32'(b_cr), 32'd0);
        chk("b_reset_ready", -1, 32'(b_ready), 32'd0);
        reset = 1'b0;
        step();
        check_a(-2, '{0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0});

        for (int i = 0; i < tab.size(); i++) begin
            drive_a(tab[i].st, tab[i].v, tab[i].d, tab[i].l);
            step();
            check_a(i, tab[i]);
        end
        drive_a(0, 0, 16'h0, 0);

        // 4-word memory: fifth word without last overflows
        drive_b(1, 0, 16'h0, 0);
        step();
        chk("b_load_ready", 0, 32'(b_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive_b(0, 1, 16'hB000 + 16'(i), 0);
            step();
            chk("b_fill_write", i, 32'(b_pw), 32'd1);
            chk("b_fill_addr", i, 32'(b_pa), 32'(i));
            chk("b_fill_data", i, 32'(b_pd), 32'hB000 + 32'(i));
        end
        drive_b(0, 1, 16'hBBBB, 0);
        step();
        chk("b_ovf_write", 0, 32'(b_pw), 32'd0);
        chk("b_ovf_error", 0, 32'(b_err), 32'd1);
        chk("b_ovf_core", 0, 32'(b_cr), 32'd0);
        chk("b_ovf_ready", 0, 32'(b_ready), 32'd0);
        chk("b_ovf_busy", 0, 32'(b_busy), 32'd0);
        chk("b_ovf_data", 0, 32'(b_pd), 32'hB003);
        step();
        chk("b_err_sticky", 0, 32'(b_err), 32'd1);
        chk("b_err_nowrite", 0, 32'(b_pw), 32'd0);
        drive_b(1, 0, 16'h0, 0);
        step();
        chk("b_restart_error", 0, 32'(b_err), 32'd0);
        chk("b_restart_ready", 0, 32'(b_ready), 32'd1);
        // exactly full image with last on the final address
        for (int i = 0; i < 4; i++) begin
            drive_b(0, 1, 16'hC000 + 16'(i), i == 3);
            step();
            chk("b_full_addr", i, 32'(b_pa), 32'(i));
            chk("b_full_write", i, 32'(b_pw), 32'd1);
        end
        chk("b_full_words", 0, 32'(b_lw), 32'd4);
        chk("b_full_error", 0, 32'(b_err), 32'd0);
        drive_b(0, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b_settle_core", i, 32'(b_cr), 32'd0);
        end
        step();
        chk("b_release_core", 0, 32'(b_cr), 32'd1);
        chk("b_release_error", 0, 32'(b_err), 32'd0);

        // asynchronous reset part-way through a load
        drive_a(1, 0, 16'h0, 0);
        step();
        drive_a(0, 1, 16'hE000, 0);
        step();
        drive_a(0, 1, 16'hE001, 0);
        step();
        chk("a_pre_rst_addr", 0, 32'(a_pa), 32'd1);
        drive_a(0, 1, 16'hE002, 0);
        #2;
        reset = 1'b1;
        #1;
        check_a(100, '{0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0});
        drive_a(0, 0, 16'h0, 0);
        step();
        reset = 1'b0;
        drive_a(1, 0, 16'h0, 0);
        step();
        drive_a(0, 1, 16'hD00D, 0);
        step();
        chk("a_reload_write", 0, 32'(a_pw), 32'd1);
        chk("a_reload_addr", 0, 32'(a_pa), 32'd0);
        chk("a_reload_data", 0, 32'(a_pd), 32'hD00D);
        drive_a(0, 0, 16'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
